// File: rtl/opc_pkg.sv
// Shared constants and types for the OPC bus responder.
// Address/data widths, default IO location and responder state.
package opc_pkg;

    localparam int OPC_ADDR_W = 11;
    localparam int OPC_DATA_W = 8;
    localparam int OPC_PAGE_BIT = 8;
    localparam logic [OPC_ADDR_W-1:0] OPC_IO_ADDR = 11'h7FF;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } resp_state_t;

endpackage

// File: rtl/opc_resp_ram.sv
// Small byte RAM: async read port, one synchronous write port.
// Contents are deliberately not reset.
module opc_resp_ram
    import opc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [OPC_DATA_W-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [OPC_DATA_W-1:0] rdata
);

    logic [OPC_DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/opc_bus_responder.sv
// OPC bus responder: boot loader, RAM and one IO port.
// Optional write counter at IO_ADDR-1 enabled by OPC_RESP_WCNT_EN.
module opc_bus_responder
    import opc_pkg::*;
#(
    parameter int ADDR_W = OPC_ADDR_W,
    parameter int DEPTH_LOG2 = 5,
    parameter logic [ADDR_W-1:0] IO_ADDR = OPC_IO_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic [OPC_DATA_W-1:0] bus_wdata,
    input  logic                  bus_rnw,
    output logic [OPC_DATA_W-1:0] bus_rdata,
    output logic                  cpu_rst_n,
    input  logic                  load_valid,
    input  logic [OPC_DATA_W-1:0] load_data,
    output logic                  load_ready,
    input  logic                  load_go,
    input  logic [OPC_DATA_W-1:0] in_port,
    output logic [OPC_DATA_W-1:0] out_port,
    output logic                  out_strobe
);

    resp_state_t state;
    logic [DEPTH_LOG2-1:0] load_ptr;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [OPC_DATA_W-1:0] ram_wdata;
    logic [OPC_DATA_W-1:0] ram_rdata;
    logic ram_we;
    logic run;
    logic is_io;
    logic io_wr;

    assign run = (state == ST_RUN);
    assign is_io = (bus_addr == IO_ADDR);
    assign io_wr = run && !bus_rnw && is_io;
    assign ram_idx = {bus_addr[OPC_PAGE_BIT], bus_addr[DEPTH_LOG2-2:0]};
    assign load_ready = !run;

    // Loader owns the write port in LOAD, the CPU owns it in RUN.
    always_comb begin
        ram_we = load_valid;
        ram_waddr = load_ptr;
        ram_wdata = load_data;
        if (run) begin
            ram_we = !bus_rnw && !is_io;
            ram_waddr = ram_idx;
            ram_wdata = bus_wdata;
        end
    end

    opc_resp_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(ram_idx),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            load_ptr <= '0;
            cpu_rst_n <= 1'b0;
            out_port <= '0;
            out_strobe <= 1'b0;
        end else begin
            cpu_rst_n <= run;
            out_strobe <= io_wr;
            if (io_wr)
                out_port <= bus_wdata;
            if (!run) begin
                if (load_valid)
                    load_ptr <= load_ptr + DEPTH_LOG2'(1);
                if (load_go)
                    state <= ST_RUN;
            end
        end
    end

`ifdef OPC_RESP_WCNT_EN
    localparam logic [ADDR_W-1:0] WCNT_ADDR = IO_ADDR - ADDR_W'(1);

    logic [7:0] wcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wcnt <= '0;
        else if (run && ram_we)
            wcnt <= wcnt + 8'd1;
    end

    always_comb begin
        bus_rdata = '0;
        if (run) begin
            if (is_io)
                bus_rdata = in_port;
            else if (bus_addr == WCNT_ADDR)
                bus_rdata = wcnt;
            else
                bus_rdata = ram_rdata;
        end
    end
`else
    always_comb begin
        bus_rdata = '0;
        if (run)
            bus_rdata = is_io ? in_port : ram_rdata;
    end
`endif

endmodule

// File: tb/tb_opc_bus_responder.sv
// Bench for opc_bus_responder: vector table, hand sequences and
// randomized RUN traffic against a behavioural memory model.
module tb_opc_bus_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] bus_addr = '0;
    logic [7:0] bus_wdata = '0;
    logic bus_rnw = 1'b1;
    logic [7:0] bus_rdata;
    logic cpu_rst_n;
    logic load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic load_ready;
    logic load_go = 1'b0;
    logic [7:0] in_port = '0;
    logic [7:0] out_port;
    logic out_strobe;

    always #5 clk = ~clk;

    opc_bus_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rnw   (bus_rnw),
        .bus_rdata (bus_rdata),
        .cpu_rst_n (cpu_rst_n),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .load_go   (load_go),
        .in_port   (in_port),
        .out_port  (out_port),
        .out_strobe(out_strobe)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_m [32];
    logic [7:0] out_m;
    int wcnt_m;
    int ptr_m;

    typedef struct {
        logic        rnw;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  inp;
        logic [7:0]  rd;
        logic        stb;
        logic [7:0]  outp;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_idx(input logic [10:0] a);
        int ai;
        ai = int'(a);
        return ((ai / 256) % 2) * 16 + (ai % 16);
    endfunction

    function automatic logic [7:0] model_read(input logic [10:0] a,
                                              input logic [7:0] inp);
        if (a == 11'h7FF)
            return inp;
`ifdef OPC_RESP_WCNT_EN
        if (a == 11'h7FE)
            return 8'(wcnt_m);
`endif
        return mem_m[ref_idx(a)];
    endfunction

    task automatic model_apply(input logic rnw, input logic [10:0] a,
                               input logic [7:0] d);
        if (!rnw) begin
            if (a == 11'h7FF) begin
                out_m = d;
            end else begin
                mem_m[ref_idx(a)] = d;
                wcnt_m = (wcnt_m + 1) % 256;
            end
        end
    endtask

    task automatic bus_cycle(input logic rnw, input logic [10:0] a,
                             input logic [7:0] d, input logic [7:0] inp,
                             input logic [7:0] exp_rd, input logic exp_stb,
                             input logic [7:0] exp_out);
        bus_rnw = rnw;
        bus_addr = a;
        bus_wdata = d;
        in_port = inp;
        #1;
        chk($sformatf("rdata@%h", a), bus_rdata, exp_rd);
        step();
        bus_rnw = 1'b1;
        chk($sformatf("out_strobe@%h", a), {7'd0, out_strobe}, {7'd0, exp_stb});
        chk($sformatf("out_port@%h", a), out_port, exp_out);
    endtask

    task automatic bus_op(input logic rnw, input logic [10:0] a,
                          input logic [7:0] d, input logic [7:0] inp);
        logic [7:0] erd;
        erd = model_read(a, inp);
        model_apply(rnw, a, d);
        bus_cycle(rnw, a, d, inp, erd, !rnw && (a == 11'h7FF), out_m);
    endtask

    task automatic load_byte(input logic [7:0] d);
        load_valid = 1'b1;
        load_data = d;
        step();
        load_valid = 1'b0;
        mem_m[ptr_m] = d;
        ptr_m = (ptr_m + 1) % 32;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        chk("rst out_port", out_port, 8'h00);
        chk("rst out_strobe", {7'd0, out_strobe}, 8'd0);
        chk("rst load_ready", {7'd0, load_ready}, 8'd1);
        out_m = 8'h00;
        wcnt_m = 0;
        ptr_m = 0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        out_m = 8'h00;
        wcnt_m = 0;
        ptr_m = 0;

        vt[0]  = '{1'b1, 11'h000, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 11'h00F, 8'h00, 8'h00, 8'h0F, 1'b0, 8'h00};
        vt[2]  = '{1'b1, 11'h100, 8'h00, 8'h00, 8'h10, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 11'h10F, 8'h00, 8'h00, 8'h1F, 1'b0, 8'h00};
        vt[4]  = '{1'b0, 11'h003, 8'hA5, 8'h00, 8'h03, 1'b0, 8'h00};
        vt[5]  = '{1'b1, 11'h003, 8'h00, 8'h00, 8'hA5, 1'b0, 8'h00};
        vt[6]  = '{1'b1, 11'h203, 8'h00, 8'h00, 8'hA5, 1'b0, 8'h00};
        vt[7]  = '{1'b0, 11'h7FF, 8'h3C, 8'h5A, 8'h5A, 1'b1, 8'h3C};
        vt[8]  = '{1'b1, 11'h10F, 8'h00, 8'h00, 8'h1F, 1'b0, 8'h3C};
        vt[9]  = '{1'b1, 11'h7FF, 8'h00, 8'h5A, 8'h5A, 1'b0, 8'h3C};
        vt[10] = '{1'b0, 11'h7FF, 8'h11, 8'h00, 8'h00, 1'b1, 8'h11};
        vt[11] = '{1'b0, 11'h7FF, 8'h22, 8'h00, 8'h00, 1'b1, 8'h22};
        vt[12] = '{1'b1, 11'h7FF, 8'h00, 8'hC3, 8'hC3, 1'b0, 8'h22};

        // Power-on reset
        #12;
        chk("por cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        chk("por out_port", out_port, 8'h00);
        chk("por out_strobe", {7'd0, out_strobe}, 8'd0);
        chk("por load_ready", {7'd0, load_ready}, 8'd1);
        chk("por rdata", bus_rdata, 8'h00);
        step();
        rst_n = 1'b1;
        step();

        // Load 0x00..0x1F then go
        for (int i = 0; i < 32; i++) begin
            load_byte(8'(i));
            if (i % 8 == 0) begin
                chk("load ready", {7'd0, load_ready}, 8'd1);
                chk("load cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
                chk("load rdata", bus_rdata, 8'h00);
            end
        end
        load_go = 1'b1;
        step();
        load_go = 1'b0;
        chk("go load_ready", {7'd0, load_ready}, 8'd0);
        chk("go cpu_rst_n hold", {7'd0, cpu_rst_n}, 8'd0);
        step();
        chk("go cpu_rst_n rise", {7'd0, cpu_rst_n}, 8'd1);

        for (int i = 0; i < 13; i++) begin
            bus_cycle(vt[i].rnw, vt[i].addr, vt[i].wdata, vt[i].inp,
                      vt[i].rd, vt[i].stb, vt[i].outp);
            model_apply(vt[i].rnw, vt[i].addr, vt[i].wdata);
        end

        // Mid-RUN reset keeps RAM; restart with load_go alone
        bus_op(1'b0, 11'h7FF, 8'h77, 8'h00);
        pulse_reset();
        load_go = 1'b1;
        step();
        load_go = 1'b0;
        step();
        chk("restart cpu_rst_n", {7'd0, cpu_rst_n}, 8'd1);
        bus_addr = 11'h100;
        #1;
        chk("retained 0x100", bus_rdata, 8'h10);
        bus_addr = 11'h003;
        #1;
        chk("retained 0x003", bus_rdata, 8'hA5);

        // Randomized RUN traffic; loader inputs must be ignored
        for (int i = 0; i < 300; i++) begin
            logic [10:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)
                a = 11'h7FF;
            else if (sel == 1)
                a = 11'h7FE;
            else
                a = 11'($urandom);
            load_valid = 1'($urandom);
            load_data = 8'($urandom);
            bus_op(1'($urandom), a, 8'($urandom), 8'($urandom));
            if (i % 50 == 0)
                chk("run load_ready", {7'd0, load_ready}, 8'd0);
        end
        load_valid = 1'b0;

        // 33-byte load wraps; last byte arrives with load_go
        pulse_reset();
        for (int i = 0; i < 32; i++)
            load_byte(8'(8'h40 + i));
        load_valid = 1'b1;
        load_data = 8'hEE;
        load_go = 1'b1;
        step();
        load_valid = 1'b0;
        load_go = 1'b0;
        mem_m[0] = 8'hEE;
        chk("wrap load_ready", {7'd0, load_ready}, 8'd0);
        step();
        chk("wrap cpu_rst_n", {7'd0, cpu_rst_n}, 8'd1);
        bus_addr = 11'h000;
        #1;
        chk("wrap 0x000", bus_rdata, 8'hEE);
        bus_addr = 11'h001;
        #1;
        chk("wrap 0x001", bus_rdata, 8'h41);
        bus_addr = 11'h10F;
        #1;
        chk("wrap 0x10F", bus_rdata, 8'h5F);
        step();

        // Write counter: 3 RAM writes and one IO write
        bus_op(1'b0, 11'h005, 8'h12, 8'h00);
        bus_op(1'b0, 11'h105, 8'h34, 8'h00);
        bus_op(1'b0, 11'h7FE, 8'h99, 8'h00);
        bus_op(1'b0, 11'h7FF, 8'h56, 8'h00);
        bus_addr = 11'h1EE;
        #1;
        chk("ram at 0x7FE alias", bus_rdata, 8'h99);
        bus_addr = 11'h7FE;
        #1;
`ifdef OPC_RESP_WCNT_EN
        chk("wcnt after 3", bus_rdata, 8'h03);
`else
        chk("ram at 0x7FE", bus_rdata, 8'h99);
`endif
        step();
        for (int i = 0; i < 253; i++)
            bus_op(1'b0, 11'(i % 30), 8'(i), 8'h00);
        bus_addr = 11'h7FE;
        bus_rnw = 1'b1;
        #1;
`ifdef OPC_RESP_WCNT_EN
        chk("wcnt wrap", bus_rdata, 8'h00);
`else
        chk("ram at 0x7FE late", bus_rdata, 8'h99);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
